// File: rtl/tohost_store_responder.sv
// Claims stores to the tohost doubleword, buffers them in a small FIFO and streams them LSB-byte first.
// Also decodes the end-of-test word into sticky done/pass/fail_code status.
module tohost_store_responder #(
  parameter logic [63:0] TOHOST_ADDR = 64'h0000_0000_0000_1000,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        done,
  output logic        pass,
  output logic [62:0] fail_code,
  output logic        overflow,
  output logic [15:0] word_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state_q, state_d;
  logic [63:0]   shift_q, shift_d;
  logic [2:0]    idx_q, idx_d;
  logic [63:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [62:0]   fail_code_q, fail_code_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   word_count_q, word_count_d;

  logic match, capture, full, not_empty, push, pop;

  assign match     = mem_write && (mem_addr[63:3] == TOHOST_ADDR[63:3]);
  assign capture   = match && !done_q;
  // Full is judged on the pre-edge count, so a same-cycle pop never makes room.
  assign full      = (count_q == DEPTH_C);
  assign not_empty = (count_q != '0);
  assign push      = capture && !full;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (not_empty) begin
          pop     = 1'b1;
          shift_d = fifo_q[rd_ptr_q];
          idx_d   = 3'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx_q != 3'd7) begin
            shift_d = {8'h00, shift_q[63:8]};
            idx_d   = idx_q + 3'd1;
          end else if (not_empty) begin
            pop     = 1'b1;
            shift_d = fifo_q[rd_ptr_q];
            idx_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d      = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
    done_d       = done_q;
    pass_d       = pass_q;
    fail_code_d  = fail_code_q;
    overflow_d   = overflow_q || (capture && full);
    word_count_d = word_count_q;
    if (push) begin
      if (word_count_q != 16'hFFFF) begin
        word_count_d = word_count_q + 16'd1;
      end
      if (mem_wdata[0]) begin
        done_d      = 1'b1;
        pass_d      = (mem_wdata[63:1] == 63'd0);
        fail_code_d = mem_wdata[63:1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      idx_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_code_q  <= '0;
      overflow_q   <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_code_q  <= fail_code_d;
      overflow_q   <= overflow_d;
      word_count_q <= word_count_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= mem_wdata;
    end
  end

  assign tx_valid   = (state_q == SEND);
  assign tx_data    = shift_q[7:0];
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_code  = fail_code_q;
  assign overflow   = overflow_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_tohost_store_responder.sv
// Directed bench for tohost_store_responder: vector table of single stores plus multi-cycle sequences.
module tb_tohost_store_responder;

  logic        clk;
  logic        rst;
  logic        mem_write;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        done;
  logic        pass;
  logic [62:0] fail_code;
  logic        overflow;
  logic [15:0] word_count;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] rxq[$];

  tohost_store_responder dut (
    .clk(clk), .rst(rst), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .done(done), .pass(pass), .fail_code(fail_code),
    .overflow(overflow), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    bit          cap;
    bit          done;
    bit          pass;
    logic [62:0] fc;
  } vec_t;

  vec_t vt[7];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mem_write = 1'b0;
    tx_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d);
    mem_write = 1'b1;
    mem_addr = a;
    mem_wdata = d;
    tick();
    mem_write = 1'b0;
  endtask

  // Gathers n accepted bytes into rxq; checks stall stability and, with steady ready, absence of gaps.
  task automatic collect(input int n, input bit toggle, input int budget);
    logic [7:0] prev;
    bit stalled;
    bit started;
    int cyc;
    int gaps;
    prev = 8'h00;
    stalled = 1'b0;
    started = 1'b0;
    cyc = 0;
    gaps = 0;
    rxq.delete();
    while (rxq.size() < n && cyc < budget) begin
      if (stalled) begin
        chk("hold_valid", {63'd0, tx_valid}, 64'd1);
        chk("hold_data", {56'd0, tx_data}, {56'd0, prev});
      end
      tx_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (tx_valid) started = 1'b1;
      else if (started) gaps++;
      stalled = tx_valid && !tx_ready;
      prev = tx_data;
      if (tx_valid && tx_ready) rxq.push_back(tx_data);
      tick();
      cyc++;
    end
    tx_ready = 1'b1;
    chk("byte_count", 64'(rxq.size()), 64'(n));
    if (!toggle) chk("no_idle_gap", 64'(gaps), 64'd0);
  endtask

  task automatic check_word(input string name, input int base, input logic [63:0] w);
    for (int b = 0; b < 8; b++) begin
      if (base + b < rxq.size()) chk(name, {56'd0, rxq[base + b]}, {56'd0, w[8*b +: 8]});
      else chk(name, 64'hDEAD, {56'd0, w[8*b +: 8]});
    end
  endtask

  task automatic expect_quiet(input string name);
    repeat (3) begin
      tick();
      chk(name, {63'd0, tx_valid}, 64'd0);
    end
  endtask

  logic [63:0] w [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    mem_write = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    tx_ready = 1'b0;

    vt[0] = '{64'h1000, 64'h0807_0605_0403_0200, 1'b1, 1'b0, 1'b0, 63'd0};
    vt[1] = '{64'h1008, 64'h1111_1111_1111_1110, 1'b0, 1'b0, 1'b0, 63'd0};
    vt[2] = '{64'h0FF8, 64'h2222_2222_2222_2220, 1'b0, 1'b0, 1'b0, 63'd0};
    vt[3] = '{64'h1004, 64'h1122_3344_5566_7788, 1'b1, 1'b0, 1'b0, 63'd0};
    vt[4] = '{64'h1000, 64'd1,                   1'b1, 1'b1, 1'b1, 63'd0};
    vt[5] = '{64'h1000, 64'd7,                   1'b1, 1'b1, 1'b0, 63'd3};
    vt[6] = '{64'h1007, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 63'h7FFF_FFFF_FFFF_FFFF};

    w[0] = 64'hA7A6_A5A4_A3A2_A1A0;
    w[1] = 64'hB7B6_B5B4_B3B2_B1B0;
    w[2] = 64'hC7C6_C5C4_C3C2_C1C0;
    w[3] = 64'hD7D6_D5D4_D3D2_D1D0;
    w[4] = 64'hE7E6_E5E4_E3E2_E1E0;
    w[5] = 64'hF7F6_F5F4_F3F2_F1F0;

    do_reset();
    chk("rst_valid", {63'd0, tx_valid}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_pass", {63'd0, pass}, 64'd0);
    chk("rst_fail_code", {1'b0, fail_code}, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    chk("rst_word_count", {48'd0, word_count}, 64'd0);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      store(vt[i].addr, vt[i].data);
      chk("vec_lat0", {63'd0, tx_valid}, 64'd0);
      chk("vec_word_count", {48'd0, word_count}, {63'd0, vt[i].cap});
      chk("vec_done", {63'd0, done}, {63'd0, vt[i].done});
      chk("vec_pass", {63'd0, pass}, {63'd0, vt[i].pass});
      chk("vec_fail_code", {1'b0, fail_code}, {1'b0, vt[i].fc});
      tx_ready = 1'b1;
      tick();
      chk("vec_lat1", {63'd0, tx_valid}, {63'd0, vt[i].cap});
      collect(vt[i].cap ? 8 : 0, 1'b0, 20);
      if (vt[i].cap) check_word("vec_byte", 0, vt[i].data);
      expect_quiet("vec_quiet");
    end

    // Address filter: neighbours rejected, low address bits ignored.
    do_reset();
    store(64'h1008, w[0]);
    store(64'h0FF8, w[1]);
    store(64'h1004, w[2]);
    chk("filter_word_count", {48'd0, word_count}, 64'd1);
    collect(8, 1'b0, 20);
    check_word("filter_byte", 0, w[2]);
    expect_quiet("filter_quiet");

    // Backpressure with alternating ready.
    do_reset();
    store(64'h1000, w[0]);
    store(64'h1000, w[1]);
    store(64'h1000, w[2]);
    collect(24, 1'b1, 200);
    for (int k = 0; k < 3; k++) check_word("bp_byte", 8 * k, w[k]);
    expect_quiet("bp_quiet");

    // Back-to-back words with steady ready.
    do_reset();
    store(64'h1000, w[3]);
    store(64'h1000, w[4]);
    store(64'h1000, w[5]);
    collect(24, 1'b0, 60);
    for (int k = 0; k < 3; k++) check_word("b2b_byte", 8 * k, w[k + 3]);

    // Overflow: 6 stores while stalled, 5 survive.
    do_reset();
    for (int k = 0; k < 6; k++) store(64'h1000, w[k]);
    chk("ovf_flag", {63'd0, overflow}, 64'd1);
    chk("ovf_word_count", {48'd0, word_count}, 64'd5);
    collect(40, 1'b0, 100);
    for (int k = 0; k < 5; k++) check_word("ovf_byte", 8 * k, w[k]);
    expect_quiet("ovf_quiet");

    // End-of-test word blocks later stores.
    do_reset();
    store(64'h1000, 64'd7);
    store(64'h1000, 64'd9);
    chk("eot_word_count", {48'd0, word_count}, 64'd1);
    chk("eot_overflow", {63'd0, overflow}, 64'd0);
    chk("eot_done", {63'd0, done}, 64'd1);
    chk("eot_pass", {63'd0, pass}, 64'd0);
    chk("eot_fail_code", {1'b0, fail_code}, 64'd3);
    collect(8, 1'b0, 20);
    check_word("eot_byte", 0, 64'd7);
    expect_quiet("eot_quiet");

    // Reset during byte 3 of the first word.
    do_reset();
    for (int k = 0; k < 6; k++) store(64'h1000, w[k]);
    begin
      bit found;
      int cyc;
      found = 1'b0;
      cyc = 0;
      tx_ready = 1'b1;
      while (!found && cyc < 20) begin
        if (tx_valid && tx_data == 8'hA3) found = 1'b1;
        else begin
          tick();
          cyc++;
        end
      end
      chk("mid_found_byte3", {63'd0, found}, 64'd1);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_valid", {63'd0, tx_valid}, 64'd0);
    chk("mid_done", {63'd0, done}, 64'd0);
    chk("mid_overflow", {63'd0, overflow}, 64'd0);
    chk("mid_word_count", {48'd0, word_count}, 64'd0);
    tx_ready = 1'b0;
    tick();
    chk("mid_still_idle", {63'd0, tx_valid}, 64'd0);
    store(64'h1000, w[5]);
    collect(8, 1'b0, 20);
    check_word("mid_byte", 0, w[5]);
    expect_quiet("mid_quiet");
    chk("mid_word_count_after", {48'd0, word_count}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
